// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_rr                                                           |
// | N-channel valid/ready arbiter in front of a single-port memory.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_arbiter_rr #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_be,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rw_mode,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic [DATA_W/8-1:0]        mem_byte_en,
    input  logic [DATA_W-1:0]          mem_read_data
);

    localparam int c_id_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_be_w = DATA_W / 8;

    logic [c_id_w-1:0]  r_rr_ptr;
    logic               w_gnt;
    logic [c_id_w-1:0]  w_gnt_id;
    logic [c_id_w-1:0]  w_idx;
    logic [NUM_CH-1:0]  w_ready;

    logic [MEM_LAT-1:0] r_pv;
    logic [MEM_LAT-1:0] r_pwe;
    logic [c_id_w-1:0]  r_pid [MEM_LAT];

    // Scan from the far end so the last hit, i.e. the first eligible channel, wins.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        if (!i_rst) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (PRIO_MODE == 1) begin
                    w_idx = c_id_w'(k);
                end else begin
                    w_idx = c_id_w'((int'(r_rr_ptr) + k) % NUM_CH);
                end
                if (req_valid[w_idx]) begin
                    w_gnt    = 1'b1;
                    w_gnt_id = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_ready        = '0;
        mem_addr       = '0;
        mem_rw_mode    = 1'b0;
        mem_write_data = '0;
        mem_byte_en    = '0;
        if (w_gnt) begin
            w_ready[w_gnt_id] = 1'b1;
            mem_addr          = req_addr[int'(w_gnt_id)*ADDR_W +: ADDR_W];
            mem_rw_mode       = req_we[w_gnt_id];
            mem_write_data    = req_wdata[int'(w_gnt_id)*DATA_W +: DATA_W];
            mem_byte_en       = req_be[int'(w_gnt_id)*c_be_w +: c_be_w];
        end
    end

    assign req_ready = w_ready;

    // The id/we pipeline never stalls: the memory returns data a fixed MEM_LAT later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
            r_pv     <= '0;
            r_pwe    <= '0;
            for (int s = 0; s < MEM_LAT; s++) begin
                r_pid[s] <= '0;
            end
        end else begin
            if (w_gnt && (PRIO_MODE == 0)) begin
                r_rr_ptr <= (w_gnt_id == c_id_w'(NUM_CH - 1)) ? '0 : w_gnt_id + 1'b1;
            end
            r_pv[0]  <= w_gnt;
            r_pwe[0] <= mem_rw_mode;
            r_pid[0] <= w_gnt_id;
            for (int s = 1; s < MEM_LAT; s++) begin
                r_pv[s]  <= r_pv[s-1];
                r_pwe[s] <= r_pwe[s-1];
                r_pid[s] <= r_pid[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (r_pv[MEM_LAT-1]) begin
            rsp_valid[r_pid[MEM_LAT-1]] = 1'b1;
            if (!r_pwe[MEM_LAT-1]) begin
                rsp_data = mem_read_data;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(req_ready));
    a_ready_valid:  assert property (@(posedge i_clk) disable iff (i_rst) ((req_ready & ~req_valid) == '0));
    a_rsp_onehot:   assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(rsp_valid));

endmodule
`default_nettype wire
